// File: rtl/cycle_controller.sv
// Instruction-cycle sequencer: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK, with HALT and FAULT.
// Latency: 4 states per instruction without MEMORY (plus fetch/memory wait cycles); pc updates on WRITEBACK exit.
// Backpressure: FETCH and MEMORY hold while mem_ready=0. Unbounded by default; with
// CYCLE_CONTROLLER_TIMEOUT_EN defined, TIMEOUT wait cycles without mem_ready force FAULT (exit by reset only).
module cycle_controller #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ready,
    input  logic              mem_access,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              compare,
    input  logic [ADDR_W-1:0] address,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              mem_req,
    output logic              ir_load,
    output logic              reg_write,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // The wait counter is 8 bits wide, so a wait bound outside 1..255 cannot be honoured.
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("cycle_controller: TIMEOUT must be in 1..255");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic              w_take;

    // Any true branch condition selects the target; jump and the conditional forms simply OR together.
    assign w_take = jump | (beq & compare) | (bne & ~compare);

`ifdef CYCLE_CONTROLLER_TIMEOUT_EN
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait;
    logic       w_expired;

    // The current cycle is the TIMEOUT-th one spent waiting in this handshake.
    assign w_expired = (r_wait >= LP_LAST);

    // Wait counter: cleared whenever the FSM changes state (covers FETCH/MEMORY entry), counts idle handshake cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait <= 8'd0;
        end else if (((r_state == S_FETCH) || (r_state == S_MEMORY)) && !mem_ready) begin
            r_wait <= r_wait + 8'd1;
        end
    end
`else
    logic w_expired;

    // Without the timeout option a handshake may wait forever.
    assign w_expired = 1'b0;
`endif

    // State register; reset overrides everything, including an in-flight handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake strobes; strobes depend only on the current state and mem_ready.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        ir_load   = 1'b0;
        reg_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_next = mem_access ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next = S_WRITEBACK;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                // halt_req is only looked at here, so an instruction is never aborted midway.
                reg_write = 1'b1;
                w_next    = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (!halt_req) begin
                    w_next = S_FETCH;
                end
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Program counter: advances (or branches) only as WRITEBACK is left; held in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (r_state == S_WRITEBACK) begin
            r_pc <= w_take ? address : (r_pc + {{(ADDR_W-1){1'b0}}, 1'b1});
        end
    end

    assign pc     = r_pc;
    assign state  = r_state;
    assign halted = (r_state == S_HALT);
`ifdef CYCLE_CONTROLLER_TIMEOUT_EN
    assign fault  = (r_state == S_FAULT);
`else
    assign fault  = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_controller.sv
// Directed + randomized bench for cycle_controller against a per-instruction reference model.
// Each instruction's expected state trace is built from the phase rules; pc follows the branch rule.
// Inputs change #1 after posedge; outputs are compared on the falling edge.
module tb_cycle_controller;

    localparam logic [15:0] TB_RESET_PC = 16'h0020;
    localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4, ST_H = 5, ST_X = 6;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic        mem_access;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        compare;
    logic [15:0] address;
    logic        halt_req;
    logic [15:0] pc;
    logic [2:0]  state;
    logic        mem_req;
    logic        ir_load;
    logic        reg_write;
    logic        halted;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pc;

    cycle_controller #(
        .ADDR_W   (16),
        .RESET_PC (TB_RESET_PC),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_ready  (mem_ready),
        .mem_access (mem_access),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .compare    (compare),
        .address    (address),
        .halt_req   (halt_req),
        .pc         (pc),
        .state      (state),
        .mem_req    (mem_req),
        .ir_load    (ir_load),
        .reg_write  (reg_write),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive handshake inputs, compare every output with the expected phase.
    task automatic cyc(input bit rdy, input bit hreq, input int es,
                       input bit er, input bit el, input bit ew);
        mem_ready = rdy;
        halt_req  = hreq;
        @(negedge clk);
        chk("state",     32'(state),     32'(es));
        chk("mem_req",   32'(mem_req),   32'(er));
        chk("ir_load",   32'(ir_load),   32'(el));
        chk("reg_write", 32'(reg_write), 32'(ew));
        chk("pc",        32'(pc),        32'(m_pc));
        chk("halted",    32'(halted),    32'(es == ST_H));
        chk("fault",     32'(fault),     32'(es == ST_X));
        @(posedge clk);
        #1;
    endtask

    // One whole instruction. hmode: 0 no halt, 1 halt_req from DECODE through WRITEBACK,
    // 2 halt_req only before WRITEBACK (must be ignored).
    task automatic instr(input int fw, input bit m, input int mw,
                         input bit j, input bit b, input bit n, input bit c,
                         input logic [15:0] a, input int hmode);
        mem_access = m;
        jump       = j;
        beq        = b;
        bne        = n;
        compare    = c;
        address    = a;
        for (int i = 0; i <= fw; i++) cyc(i == fw, hmode == 2, ST_F, 1'b1, i == fw, 1'b0);
        cyc(bit'($urandom % 2), hmode != 0, ST_D, 1'b0, 1'b0, 1'b0);
        cyc(bit'($urandom % 2), hmode != 0, ST_E, 1'b0, 1'b0, 1'b0);
        if (m) begin
            for (int i = 0; i <= mw; i++) cyc(i == mw, hmode != 0, ST_M, 1'b1, 1'b0, 1'b0);
        end
        cyc(bit'($urandom % 2), hmode == 1, ST_W, 1'b0, 1'b0, 1'b1);
        if (j || (b && c) || (n && !c)) m_pc = a;
        else                            m_pc = m_pc + 16'd1;
    endtask

    // Stay halted for k cycles, then release; the following cycle is a FETCH.
    task automatic halt_cycles(input int k);
        for (int i = 0; i < k; i++) cyc(bit'($urandom % 2), 1'b1, ST_H, 1'b0, 1'b0, 1'b0);
        cyc(bit'($urandom % 2), 1'b0, ST_H, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        mem_ready  = 1'b0;
        mem_access = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        compare    = 1'b0;
        address    = 16'h0000;
        halt_req   = 1'b1;
        m_pc       = TB_RESET_PC;

        // Reset state, with other inputs active to show reset wins.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_state",   32'(state),   32'(ST_F));
        chk("rst_pc",      32'(pc),      32'(TB_RESET_PC));
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_fault",   32'(fault),   32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        halt_req = 1'b0;

        // Straight-line instructions, mem_ready immediate: 0,1,2,4 per instruction.
        repeat (3) instr(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 0);
        // Memory phase with 3 wait cycles.
        instr(0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
        // Fetch waits.
        instr(2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
        // Branches.
        instr(0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 0);
        instr(0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 0);
        instr(0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 0);
        instr(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 0);
        instr(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 0);
        chk("pc_wrap", 32'(m_pc), 32'h0000);
        // Halt requested in DECODE: instruction completes, then HALT, release to FETCH.
        instr(1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1);
        halt_cycles(3);
        // halt_req before WRITEBACK only: no halt.
        instr(0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 2);

        // Reset while waiting in MEMORY: next cycle FETCH at RESET_PC, no reg_write.
        mem_access = 1'b1;
        jump = 1'b0; beq = 1'b0; bne = 1'b0;
        cyc(1'b1, 1'b0, ST_F, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, ST_D, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ST_E, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, ST_M, 1'b1, 1'b0, 1'b0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rstmem_state", 32'(state), 32'(ST_M));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = TB_RESET_PC;
        cyc(1'b0, 1'b0, ST_F, 1'b1, 1'b0, 1'b0);

        // Fetch with no mem_ready: bounded only when the timeout option is built in.
`ifdef CYCLE_CONTROLLER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, ST_F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(bit'($urandom % 2), 1'b0, ST_X, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, ST_F, 1'b1, 1'b0, 1'b0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = TB_RESET_PC;

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++) begin
            int          fw, mw, sel, hsel;
            bit          m, c;
            logic [15:0] a;
            fw   = int'($urandom % 3);
            mw   = int'($urandom % 4);
            m    = bit'($urandom % 2);
            c    = bit'($urandom % 2);
            sel  = int'($urandom % 4);
            hsel = int'($urandom % 6);
            a    = 16'($urandom);
            instr(fw, m, mw, sel == 1, sel == 2, sel == 3, c, a,
                  (hsel == 0) ? 1 : ((hsel == 1) ? 2 : 0));
            if (hsel == 0) halt_cycles(int'($urandom % 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
